// File: rtl/vga_dual_mode_timing_if.sv
// VGA DAC-side bundle: 6-bit-per-channel colour plus horizontal/vertical sync.
// The timing generator drives it through master; the DAC/monitor side uses slave.
interface vga_dual_mode_timing_if;
  logic [5:0] VGA_R;
  logic [5:0] VGA_G;
  logic [5:0] VGA_B;
  logic       VGA_HS;
  logic       VGA_VS;

  modport master (output VGA_R, output VGA_G, output VGA_B, output VGA_HS, output VGA_VS);
  modport slave  (input  VGA_R, input  VGA_G, input  VGA_B, input  VGA_HS, input  VGA_VS);
endinterface

// File: rtl/vga_dual_mode_timing.sv
// Dual-mode VGA timing generator (640x480@60 / 800x600@72) with 8-bar colour source.
// Optional macro VGA_BORDER_EN paints a one-pixel white frame around the active area.
module vga_dual_mode_timing #(
  parameter int HS_Tpw640_480 = 95,
  parameter int HS_Ts640_480  = 799,
  parameter int VS_Tpw640_480 = 1,
  parameter int VS_Ts640_480  = 524,
  parameter int HS_Tbp640_480 = 48,
  parameter int HS_Tfp640_480 = 17,
  parameter int VS_Tbp640_480 = 33,
  parameter int VS_Tfp640_480 = 11,
  parameter int HS_Tpw800_600 = 119,
  parameter int HS_Ts800_600  = 1039,
  parameter int VS_Tpw800_600 = 5,
  parameter int VS_Ts800_600  = 665,
  parameter int HS_Tbp800_600 = 64,
  parameter int HS_Tfp800_600 = 57,
  parameter int VS_Tbp800_600 = 23,
  parameter int VS_Tfp800_600 = 38,
  parameter int CLK_DIV_640   = 4,
  parameter int CLK_DIV_800   = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          sw,
  vga_dual_mode_timing_if.master        vga
);

  typedef struct packed {
    logic [15:0] tpw_h;
    logic [15:0] ts_h;
    logic [15:0] hstart;
    logic [15:0] hend;
    logic [15:0] tpw_v;
    logic [15:0] ts_v;
    logic [15:0] vstart;
    logic [15:0] vend;
    logic [15:0] act_w;
    logic [15:0] bar_w;
    logic [3:0]  div_max;
  } timing_t;

  localparam logic [15:0] HSTART0 = 16'(HS_Tpw640_480 + HS_Tbp640_480);
  localparam logic [15:0] HEND0   = 16'(HS_Ts640_480 - HS_Tfp640_480);
  localparam logic [15:0] ACTW0   = HEND0 - HSTART0 + 16'd1;
  localparam logic [15:0] HSTART1 = 16'(HS_Tpw800_600 + HS_Tbp800_600);
  localparam logic [15:0] HEND1   = 16'(HS_Ts800_600 - HS_Tfp800_600);
  localparam logic [15:0] ACTW1   = HEND1 - HSTART1 + 16'd1;

  localparam timing_t T0 = '{
    tpw_h:   16'(HS_Tpw640_480),
    ts_h:    16'(HS_Ts640_480),
    hstart:  HSTART0,
    hend:    HEND0,
    tpw_v:   16'(VS_Tpw640_480),
    ts_v:    16'(VS_Ts640_480),
    vstart:  16'(VS_Tpw640_480 + VS_Tbp640_480),
    vend:    16'(VS_Ts640_480 - VS_Tfp640_480),
    act_w:   ACTW0,
    bar_w:   ACTW0 >> 3,
    div_max: 4'(CLK_DIV_640 - 1)
  };

  localparam timing_t T1 = '{
    tpw_h:   16'(HS_Tpw800_600),
    ts_h:    16'(HS_Ts800_600),
    hstart:  HSTART1,
    hend:    HEND1,
    tpw_v:   16'(VS_Tpw800_600),
    ts_v:    16'(VS_Ts800_600),
    vstart:  16'(VS_Tpw800_600 + VS_Tbp800_600),
    vend:    16'(VS_Ts800_600 - VS_Tfp800_600),
    act_w:   ACTW1,
    bar_w:   ACTW1 >> 3,
    div_max: 4'(CLK_DIV_800 - 1)
  };

  logic        sw_meta_q, sw_meta_d;
  logic        sw_sync_q, sw_sync_d;
  logic        mode_q,    mode_d;
  logic [3:0]  div_q,     div_d;
  logic [15:0] hcnt_q,    hcnt_d;
  logic [15:0] vcnt_q,    vcnt_d;
  logic [5:0]  r_q,       r_d;
  logic [5:0]  g_q,       g_d;
  logic [5:0]  b_q,       b_d;
  logic        hs_q,      hs_d;
  logic        vs_q,      vs_d;

  timing_t     tm;
  logic        pix_en;
  logic        active;
  logic [15:0] x;
  logic [2:0]  bar_idx;
  logic [2:0]  rgb_bits;

  assign tm     = mode_q ? T1 : T0;
  assign pix_en = (div_q == tm.div_max);
  assign x      = hcnt_q - tm.hstart;
  assign active = (hcnt_q >= tm.hstart) && (hcnt_q <= tm.hend) &&
                  (vcnt_q >= tm.vstart) && (vcnt_q <= tm.vend);

  // Bar index by threshold compare; avoids a divider for the 80/100 px bar width.
  always_comb begin
    bar_idx = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (x >= 16'(i) * tm.bar_w) bar_idx = 3'(i);
    end
  end

  // {R,G,B} on/off per bar: white, yellow, cyan, green, magenta, red, blue, black.
  always_comb begin
    rgb_bits = 3'b000;
    case (bar_idx)
      3'd0:    rgb_bits = 3'b111;
      3'd1:    rgb_bits = 3'b110;
      3'd2:    rgb_bits = 3'b011;
      3'd3:    rgb_bits = 3'b010;
      3'd4:    rgb_bits = 3'b101;
      3'd5:    rgb_bits = 3'b100;
      3'd6:    rgb_bits = 3'b001;
      default: rgb_bits = 3'b000;
    endcase
`ifdef VGA_BORDER_EN
    if (x == 16'd0 || x == tm.act_w - 16'd1 ||
        vcnt_q == tm.vstart || vcnt_q == tm.vend) rgb_bits = 3'b111;
`endif
    if (!active) rgb_bits = 3'b000;
  end

  always_comb begin
    sw_meta_d = sw;
    sw_sync_d = sw_meta_q;
    mode_d    = mode_q;
    div_d     = pix_en ? 4'd0 : div_q + 4'd1;
    hcnt_d    = hcnt_q;
    vcnt_d    = vcnt_q;
    r_d       = r_q;
    g_d       = g_q;
    b_d       = b_q;
    hs_d      = hs_q;
    vs_d      = vs_q;
    if (pix_en) begin
      // Outputs reflect the pre-increment counters: one pixel of lag.
      hs_d = (hcnt_q <= tm.tpw_h) ? mode_q : ~mode_q;
      vs_d = (vcnt_q <= tm.tpw_v) ? mode_q : ~mode_q;
      r_d  = {6{rgb_bits[2]}};
      g_d  = {6{rgb_bits[1]}};
      b_d  = {6{rgb_bits[0]}};
      if (hcnt_q == tm.ts_h) begin
        hcnt_d = 16'd0;
        if (vcnt_q == tm.ts_v) begin
          vcnt_d = 16'd0;
          // Mode is only ever taken at the frame boundary, so frames are never cut short.
          mode_d = sw_sync_q;
        end else begin
          vcnt_d = vcnt_q + 16'd1;
        end
      end else begin
        hcnt_d = hcnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta_q <= 1'b0;
      sw_sync_q <= 1'b0;
      mode_q    <= 1'b0;
      div_q     <= 4'd0;
      hcnt_q    <= 16'd0;
      vcnt_q    <= 16'd0;
      r_q       <= 6'd0;
      g_q       <= 6'd0;
      b_q       <= 6'd0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
    end else begin
      sw_meta_q <= sw_meta_d;
      sw_sync_q <= sw_sync_d;
      mode_q    <= mode_d;
      div_q     <= div_d;
      hcnt_q    <= hcnt_d;
      vcnt_q    <= vcnt_d;
      r_q       <= r_d;
      g_q       <= g_d;
      b_q       <= b_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
    end
  end

  assign vga.VGA_R  = r_q;
  assign vga.VGA_G  = g_q;
  assign vga.VGA_B  = b_q;
  assign vga.VGA_HS = hs_q;
  assign vga.VGA_VS = vs_q;

endmodule

// File: tb/tb_vga_dual_mode_timing.sv
// Directed bench: horizontal timing at full size, vertical timing shrunk to 10/8-line frames.
// Pixel (h,v) of a frame shows on the outputs just after edge CLK_DIV*(v*line_len+h+1).
module tb_vga_dual_mode_timing;
  logic clk;
  logic rst_n;
  logic sw;
  int unsigned cyc;
  int unsigned t0;
  int errors;
  int checks;

  localparam logic [17:0] BLACK  = 18'h00000;
  localparam logic [17:0] WHITE  = {6'h3f, 6'h3f, 6'h3f};
  localparam logic [17:0] YELLOW = {6'h3f, 6'h3f, 6'h00};
  localparam logic [17:0] GREEN  = {6'h00, 6'h3f, 6'h00};
  localparam logic [17:0] BLUE   = {6'h00, 6'h00, 6'h3f};

  vga_dual_mode_timing_if vif ();

  vga_dual_mode_timing #(
    .VS_Ts640_480 (9), .VS_Tbp640_480 (2), .VS_Tfp640_480 (2),
    .VS_Tpw800_600(1), .VS_Ts800_600 (7), .VS_Tbp800_600(1), .VS_Tfp800_600(1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .sw   (sw),
    .vga  (vif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, cyc - t0);
    end
  endtask

  // Advance to just after the n-th rising edge since the last reset release.
  task automatic goto(input int unsigned n);
    while (cyc - t0 < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [17:0] rgb();
    return {vif.VGA_R, vif.VGA_G, vif.VGA_B};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("rst_rgb", 32'(rgb()), 32'(BLACK));
    chk("rst_hs", 32'(vif.VGA_HS), 32'd1);
    chk("rst_vs", 32'(vif.VGA_VS), 32'd1);
    rst_n = 1'b1;
    t0 = cyc;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    cyc    = 0;
    t0     = 0;
    sw     = 1'b0;
    rst_n  = 1'b0;
    do_reset();

    // Mode 0 horizontal: low 96 px, period 800 px of 4 clk.
    goto(3);     chk("hs_pre_first", 32'(vif.VGA_HS), 32'd1);
    goto(4);     chk("hs_first_fall", 32'(vif.VGA_HS), 32'd0);
    goto(384);   chk("hs_last_low", 32'(vif.VGA_HS), 32'd0);
    goto(388);   chk("hs_rise", 32'(vif.VGA_HS), 32'd1);
    goto(3200);  chk("hs_line_end", 32'(vif.VGA_HS), 32'd1);
    goto(3204);  chk("hs_period", 32'(vif.VGA_HS), 32'd0);
    goto(6400);  chk("vs_last_low", 32'(vif.VGA_VS), 32'd0);
    goto(6404);  chk("vs_rise", 32'(vif.VGA_VS), 32'd1);

    // Mode 0 colour; active rows 3..7, columns 143..782.
    goto(8004);  chk("blank_row2", 32'(rgb()), 32'(BLACK));
    sw = 1'b1;
    goto(13372); chk("blank_col142", 32'(rgb()), 32'(BLACK));
    goto(13376); chk("bar_x0_white", 32'(rgb()), 32'(WHITE));
    goto(13696); chk("bar_x80_yellow", 32'(rgb()), 32'(YELLOW));
    sw = 1'b0;
    goto(15612); chk("bar_x559_blue", 32'(rgb()), 32'(BLUE));
`ifdef VGA_BORDER_EN
    goto(15932); chk("bar_x639_border", 32'(rgb()), 32'(WHITE));
`else
    goto(15932); chk("bar_x639_black", 32'(rgb()), 32'(BLACK));
`endif
    goto(15936); chk("blank_col783", 32'(rgb()), 32'(BLACK));
    sw = 1'b1;
`ifdef VGA_BORDER_EN
    goto(24004); chk("row7_border", 32'(rgb()), 32'(WHITE));
`else
    goto(24004); chk("row7_green", 32'(rgb()), 32'(GREEN));
`endif
    goto(27204); chk("blank_row8", 32'(rgb()), 32'(BLACK));

    // Toggles mid-frame must not cut the mode 0 frame short.
    goto(28804); chk("m0_hold_hs", 32'(vif.VGA_HS), 32'd0);
    goto(32000); chk("m0_last_hs", 32'(vif.VGA_HS), 32'd1);
    goto(32000); chk("m0_last_vs", 32'(vif.VGA_VS), 32'd1);

    // Mode 1 from edge 32000: 2 clk/pixel, 1040 px/line, active-high syncs.
    goto(32002); chk("m1_hs_first", 32'(vif.VGA_HS), 32'd1);
    goto(32002); chk("m1_vs_first", 32'(vif.VGA_VS), 32'd1);
    goto(32004); chk("m1_hs_px1", 32'(vif.VGA_HS), 32'd1);
    goto(32240); chk("m1_hs_last_hi", 32'(vif.VGA_HS), 32'd1);
    goto(32242); chk("m1_hs_fall", 32'(vif.VGA_HS), 32'd0);
    goto(34080); chk("m1_line_end", 32'(vif.VGA_HS), 32'd0);
    goto(34082); chk("m1_hs_period", 32'(vif.VGA_HS), 32'd1);
    goto(36160); chk("m1_vs_last_hi", 32'(vif.VGA_VS), 32'd1);
    goto(36162); chk("m1_vs_fall", 32'(vif.VGA_VS), 32'd0);
    goto(38608); chk("m1_x0_white", 32'(rgb()), 32'(WHITE));
    goto(38806); chk("m1_x99_white", 32'(rgb()), 32'(WHITE));
    goto(38808); chk("m1_x100_yellow", 32'(rgb()), 32'(YELLOW));

    // Async reset mid-line in mode 1: outputs must drop at once, not on a clock.
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rgb", 32'(rgb()), 32'(BLACK));
    chk("async_hs", 32'(vif.VGA_HS), 32'd1);
    chk("async_vs", 32'(vif.VGA_VS), 32'd1);
    do_reset();
    goto(3);     chk("re_hs_pre", 32'(vif.VGA_HS), 32'd1);
    goto(4);     chk("re_hs_fall", 32'(vif.VGA_HS), 32'd0);
    goto(388);   chk("re_hs_rise", 32'(vif.VGA_HS), 32'd1);
    goto(3204);  chk("re_hs_period", 32'(vif.VGA_HS), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
